mmul_seq: RTL and testbench
===========================

# mmul_seq

Operand sequencer sitting directly upstream of the 256-bit word-serial modular multiplier. It accepts a valid/ready stream of 16-bit words from the host side and drives the multiplier's load strobes and data bus. It launches the multiplication, waits for completion, then unloads the 16-word result through its output strobe as a valid/ready stream. It returns carry/status flags with the last result word.

## Interface
Parameters:
- WORDS, 16: words per operand (256/16); the counter is clog2(WORDS) bits.
- W, 16: word width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- skip_p  in  1  sampled with start; 1 = reuse the resident modulus and skip the P load.
- abort  in  1  synchronous; returns to IDLE from any state.
- in_data  in  W  operand word, least-significant word first.
- in_valid  in  1  input word valid.
- in_ready  out  1  high only in LOAD_P / LOAD_A / LOAD_B.
- out_data  out  W  result word, least-significant word first.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with word WORDS-1.
- out_cflag  out  2  multiplier c_flag, captured at completion and held until the next start.
- busy  out  1  high in any state other than IDLE.
- mm_datain  out  W  registered word to the multiplier.
- mm_loadp, mm_loada, mm_loadb  out  1  registered load strobes.
- mm_en  out  1  one-cycle start pulse to the multiplier.
- mm_outc  out  1  result rotate strobe.
- mm_rdy  in  1  multiplier done (level).
- mm_cflag  in  2  multiplier carry flags.
- mm_c  in  W  multiplier result word (current LSW).

## Operation
- States and transitions:
  - IDLE: on start, go to LOAD_P, or to LOAD_A if skip_p=1.
  - LOAD_P, LOAD_A, LOAD_B: each takes WORDS words, then moves to the next load state. After the last LOAD_B word, go to RUN.
  - RUN: one cycle, then ARM.
  - ARM: one cycle, then WAIT.
  - WAIT: go to UNLOAD when mm_rdy=1.
  - UNLOAD: after WORDS result words, go to IDLE.
- Load path:
  - A word fires when in_valid & in_ready.
  - On a fire: mm_datain <= in_data and the matching strobe <= 1. Otherwise all strobes <= 0, so there is exactly one strobe per accepted word.
  - The word counter wraps to 0 at the end of each operand.
- RUN drives mm_en=1 for exactly one cycle, which is one cycle after the last mm_loadb pulse.
- ARM ignores mm_rdy, because the multiplier's stale ready from the previous operation is cleared by mm_en.
- Multiplier contract: mm_c presents the current LSW. One cycle of mm_outc rotates the result so the next word appears the following cycle.
- Unload path:
  - mm_outc = UNLOAD & (!out_valid | out_ready) & (words remaining).
  - out_data <= mm_c and out_valid <= 1 in the same cycle as mm_outc.
  - out_valid drops after acceptance when no further word is issued.
  - Leave UNLOAD once the last word is accepted.
- mm_cflag is captured into out_cflag on the WAIT->UNLOAD transition.
- abort:
  - Takes priority over every transition.
  - Clears strobes, mm_en, mm_outc, out_valid and the counter.
  - Leaves multiplier contents undefined; the next operation must not use skip_p.
- Simultaneous events:
  - start while busy is ignored.
  - abort and start in the same cycle: abort wins and the block stays IDLE.
  - in_valid outside load states is not accepted.

## Timing
- Reset values: state IDLE, counter 0, every output 0 (out_cflag 2'b00, busy 0, in_ready 0).
- Load latency: an input fire in cycle t gives its strobe and mm_datain in cycle t+1.
- start (t) gives in_ready=1 at t+1.
- Minimum cycles from start to mm_en:
  - 1 + 3·WORDS + 1 = 50, with no input stalls.
  - 34 when skip_p=1.
- mm_rdy seen in cycle t gives the first mm_outc at t+1 (UNLOAD entry).
- With out_ready held at 1, one word is emitted per cycle and the unload takes WORDS cycles.
- Backpressure: mm_outc never pulses while out_valid & !out_ready, so no result word is lost.

## Structure
- Shared package:
  - State enum (IDLE, LOAD_P, LOAD_A, LOAD_B, RUN, ARM, WAIT, UNLOAD).
  - WORDS and W constants.
  - c_flag width.
- Single module; no sub-module is needed. A word counter is inlined; a generic counter module already exists but adds nothing here.

## Test plan
- Full load: start, skip_p=0, 48 words 0x0000..0x002F with no stalls.
  - Required: 16 mm_loadp strobes, then 16 mm_loada, then 16 mm_loadb, with mm_datain matching input order.
  - Required: mm_en at cycle 50 after start, lasting exactly 1 cycle.
- skip_p=1: 32 words.
  - Required: no mm_loadp pulse, and mm_en 34 cycles after start.
- Stale ready: mm_rdy held at 1 through RUN/ARM, multiplier model clears it and then raises it 300 cycles later.
  - Required: UNLOAD is entered only after that rise.
- Unload backpressure: mm_c returns 0xC000+k, out_ready toggles 1,0,0,1 repeating.
  - Required: 16 words 0xC000..0xC00F in order, out_last only on 0xC00F.
  - Required: exactly 16 mm_outc pulses.
  - Required: out_cflag equals the mm_cflag value (2'b10) present at completion.
- abort during LOAD_A word 7.
  - Required: IDLE next cycle, all strobes low, busy=0.
  - Required: a following start runs a clean full sequence.
- rst asserted mid-UNLOAD.
  - Required: all outputs 0 immediately (asynchronously).
  - Required: after release, start is accepted normally.

Source files
------------

// File: rtl/mmul_seq_pkg.sv
// Shared definitions for the modular-multiplier operand sequencer:
// default geometry, carry-flag width and the sequencer state encoding.
package mmul_seq_pkg;

    // 256-bit operands carried as 16 words of 16 bits.
    localparam int WORDS_DEF = 16;
    localparam int W_DEF     = 16;

    // Width of the multiplier's carry/status flags.
    localparam int CFLAG_W   = 2;

    // Sequencer states, in the order an operation walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_P = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_RUN    = 3'd4,
        ST_ARM    = 3'd5,
        ST_WAIT   = 3'd6,
        ST_UNLOAD = 3'd7
    } state_t;

    // True in the three states that accept operand words from the host.
    function automatic logic is_load_state(input state_t s);
        return (s == ST_LOAD_P) || (s == ST_LOAD_A) || (s == ST_LOAD_B);
    endfunction

endpackage

// File: rtl/mmul_seq.sv
// Operand sequencer for the word-serial modular multiplier. It streams
// P (optional), A and B into the multiplier through registered load strobes,
// fires a one-cycle start pulse, waits for completion and then unloads the
// result as a valid/ready stream with the carry flags alongside.
module mmul_seq
    import mmul_seq_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int W     = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               skip_p,
    input  logic               abort,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CFLAG_W-1:0] out_cflag,
    output logic               busy,
    output logic [W-1:0]       mm_datain,
    output logic               mm_loadp,
    output logic               mm_loada,
    output logic               mm_loadb,
    output logic               mm_en,
    output logic               mm_outc,
    input  logic               mm_rdy,
    input  logic [CFLAG_W-1:0] mm_cflag,
    input  logic [W-1:0]       mm_c
);

    localparam int            CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic                 issued_all_q;
    logic [W-1:0]         mm_datain_q;
    logic                 mm_loadp_q, mm_loada_q, mm_loadb_q;
    logic                 mm_en_q;
    logic [W-1:0]         out_data_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [CFLAG_W-1:0]   out_cflag_q;

    logic                 load_fire;
    logic                 cnt_at_last;
    logic                 out_accept;
    logic                 unload_issue;
    logic                 finish_wait;

    // Handshake and event decodes shared by the FSM and the datapath.
    assign in_ready     = is_load_state(state_q);
    assign load_fire    = in_valid & in_ready;
    assign cnt_at_last  = (cnt_q == CNT_LAST);
    assign out_accept   = out_valid_q & out_ready;
    // Rotate the next result word out only while the output register is
    // free or being drained this cycle, so no word is ever overwritten.
    assign unload_issue = (state_q == ST_UNLOAD) & (~out_valid_q | out_ready)
                          & ~issued_all_q & ~abort;
    assign finish_wait  = (state_q == ST_WAIT) & mm_rdy;

    assign busy      = (state_q != ST_IDLE);
    assign mm_outc   = unload_issue;
    assign mm_datain = mm_datain_q;
    assign mm_loadp  = mm_loadp_q;
    assign mm_loada  = mm_loada_q;
    assign mm_loadb  = mm_loadb_q;
    assign mm_en     = mm_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_cflag = out_cflag_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = skip_p ? ST_LOAD_A : ST_LOAD_P;
                    end
                end
                ST_LOAD_P: begin
                    if (load_fire && cnt_at_last) begin
                        state_d = ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (load_fire && cnt_at_last) begin
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (load_fire && cnt_at_last) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_ARM;
                end
                // The multiplier's ready may still be high from the last
                // operation; it only clears once mm_en has been seen, so
                // ARM never looks at it.
                ST_ARM: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_rdy) begin
                        state_d = ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (out_accept && out_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Word counter: counts accepted operand words, wrapping at the end of
    // each operand, then counts result words issued during unload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            issued_all_q <= 1'b0;
        end else if (abort) begin
            cnt_q        <= '0;
            issued_all_q <= 1'b0;
        end else if (load_fire) begin
            cnt_q <= cnt_at_last ? '0 : cnt_q + 1'b1;
        end else if (finish_wait) begin
            cnt_q        <= '0;
            issued_all_q <= 1'b0;
        end else if (unload_issue) begin
            cnt_q <= cnt_at_last ? '0 : cnt_q + 1'b1;
            if (cnt_at_last) begin
                issued_all_q <= 1'b1;
            end
        end
    end

    // Load path: one registered strobe per accepted word, data alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_datain_q <= '0;
            mm_loadp_q  <= 1'b0;
            mm_loada_q  <= 1'b0;
            mm_loadb_q  <= 1'b0;
        end else begin
            mm_loadp_q <= 1'b0;
            mm_loada_q <= 1'b0;
            mm_loadb_q <= 1'b0;
            if (load_fire && !abort) begin
                mm_datain_q <= in_data;
                mm_loadp_q  <= (state_q == ST_LOAD_P);
                mm_loada_q  <= (state_q == ST_LOAD_A);
                mm_loadb_q  <= (state_q == ST_LOAD_B);
            end
        end
    end

    // Start pulse: registered from RUN, so it lands one cycle after the
    // final B strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_en_q <= 1'b0;
        end else begin
            mm_en_q <= (state_q == ST_RUN) && !abort;
        end
    end

    // Carry flags: cleared when a new operation is accepted, captured as
    // the multiplier reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cflag_q <= '0;
        end else if (!abort) begin
            if (state_q == ST_IDLE && start) begin
                out_cflag_q <= '0;
            end else if (finish_wait) begin
                out_cflag_q <= mm_cflag;
            end
        end
    end

    // Result stream register: captures the multiplier's current LSW in the
    // same cycle it is rotated, and drops valid once drained with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (unload_issue) begin
            out_data_q  <= mm_c;
            out_valid_q <= 1'b1;
            out_last_q  <= cnt_at_last;
        end else if (out_accept) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmul_seq.sv
// Scoreboard bench for mmul_seq: operations are issued with random operand
// words, a behavioural multiplier answers, and a negedge monitor compares
// every load strobe and every accepted result word against queued
// expectations.
module tb_mmul_seq;

    localparam int WORDS = 16;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         skip_p = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [1:0]   out_cflag;
    logic         busy;
    logic [W-1:0] mm_datain;
    logic         mm_loadp, mm_loada, mm_loadb;
    logic         mm_en;
    logic         mm_outc;
    logic         mm_rdy = 1'b1;
    logic [1:0]   mm_cflag;
    logic [W-1:0] mm_c;

    mmul_seq #(.WORDS(WORDS), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .skip_p(skip_p), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_cflag(out_cflag), .busy(busy),
        .mm_datain(mm_datain), .mm_loadp(mm_loadp), .mm_loada(mm_loada),
        .mm_loadb(mm_loadb), .mm_en(mm_en), .mm_outc(mm_outc),
        .mm_rdy(mm_rdy), .mm_cflag(mm_cflag), .mm_c(mm_c)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural multiplier ----------------
    // Ready stays at its old level until mm_en is seen, then drops and rises
    // again after mm_lat cycles. The result is mm_rbase+k where k counts
    // rotations; the flags read correctly only until the first rotation.
    int           mm_lat = 20;
    logic [W-1:0] mm_rbase = 16'hC000;
    logic [1:0]   mm_cf = 2'b01;
    int           mm_cnt = 0;
    logic [W-1:0] mm_k = '0;
    int           mm_rot = 0;

    always @(posedge clk) begin
        if (mm_en) begin
            mm_rdy <= 1'b0;
            mm_cnt <= mm_lat;
            mm_k   <= '0;
            mm_rot <= 0;
        end else begin
            if (mm_cnt == 1) mm_rdy <= 1'b1;
            if (mm_cnt > 0) mm_cnt <= mm_cnt - 1;
            if (mm_outc) begin
                mm_k   <= mm_k + 1'b1;
                mm_rot <= mm_rot + 1;
            end
        end
    end
    assign mm_c     = mm_rbase + mm_k;
    assign mm_cflag = (mm_rot == 0) ? mm_cf : ~mm_cf;

    // ---------------- downstream ready pattern ----------------
    int or_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int           kind;   // 0 = P, 1 = A, 2 = B
        logic [W-1:0] data;
    } ld_t;

    ld_t          load_q[$];
    logic [W-1:0] out_q[$];
    logic [1:0]   exp_cflag = 2'b00;

    int   en_cnt = 0, en_cyc = 0, outc_cnt = 0, outc_cyc = 0, rise_cyc = 0;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin : monitor
        ld_t          e;
        logic [W-1:0] od;
        logic [2:0]   oh;
        bit           is_last;
        if (!rst) begin
            if (mm_loadp || mm_loada || mm_loadb) begin
                if (load_q.size() == 0) begin
                    fail_now("load_strobe_unexpected");
                end else begin
                    e  = load_q.pop_front();
                    oh = 3'b100 >> e.kind;
                    chk("load_strobe", 32'({mm_loadp, mm_loada, mm_loadb}), 32'(oh));
                    chk("load_data", 32'(mm_datain), 32'(e.data));
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    fail_now("out_word_unexpected");
                end else begin
                    is_last = (out_q.size() == 1);
                    od = out_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(od));
                    chk("out_last", 32'(out_last), 32'(is_last));
                    if (is_last) chk("out_cflag", 32'(out_cflag), 32'(exp_cflag));
                end
            end
            if (mm_en) begin
                en_cnt++;
                if (en_cnt == 1) en_cyc = cyc;
            end
            if (mm_outc) begin
                outc_cnt++;
                if (outc_cnt == 1) outc_cyc = cyc;
            end
            if (mm_rdy && !rdy_prev) rise_cyc = cyc;
        end
        rdy_prev = mm_rdy;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        chk({tag, "_out_cflag"}, 32'(out_cflag), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_in_ready"},  32'(in_ready), 0);
        chk({tag, "_mm_datain"}, 32'(mm_datain), 0);
        chk({tag, "_strobes"},   32'({mm_loadp, mm_loada, mm_loadb, mm_en, mm_outc}), 0);
    endtask

    // One operation. abort_idx >= 0 aborts while offering that word;
    // exp_lat > 0 checks start-to-mm_en latency; rst_mid resets mid-unload.
    int op_no = 0;
    task automatic run_op(input bit skip, input bit stalls, input int abort_idx,
                          input int exp_lat, input int lat, input logic [W-1:0] rbase,
                          input logic [1:0] cf, input bit rst_mid, input bit idx_data);
        int           nload;
        int           start_cyc;
        int           tmo;
        bit           fired;
        logic [W-1:0] words[$];
        logic [W-1:0] d;
        nload = skip ? 2 * WORDS : 3 * WORDS;
        op_no++;
        mm_lat = lat; mm_rbase = rbase; mm_cf = cf; exp_cflag = cf;
        en_cnt = 0; outc_cnt = 0; en_cyc = 0; outc_cyc = 0;
        for (int i = 0; i < nload; i++) begin
            d = idx_data ? W'(i) : W'($urandom);
            words.push_back(d);
            if (abort_idx < 0 || i < abort_idx)
                load_q.push_back('{kind: (skip ? 1 : 0) + i / WORDS, data: d});
        end
        if (abort_idx < 0)
            for (int k = 0; k < WORDS; k++) out_q.push_back(rbase + W'(k));

        // First word is already offered while start is high (IDLE must not take it).
        start = 1'b1; skip_p = skip; in_valid = 1'b1; in_data = words[0];
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("in_ready_after_start", 32'(in_ready), 1);

        for (int i = 0; i < nload; i++) begin
            if (stalls) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0; @(posedge clk); #1;
                end
            end
            in_valid = 1'b1; in_data = words[i];
            start = (i == 5);                 // start while busy must be ignored
            if (i == abort_idx) abort = 1'b1;
            fired = 0; tmo = 0;
            while (!fired && tmo < 200) begin
                @(negedge clk); fired = in_ready;
                @(posedge clk); #1; tmo++;
            end
            start = 1'b0;
            if (!fired) begin
                fail_now("input_word_timeout");
                in_valid = 1'b0; abort = 1'b0;
                return;
            end
            if (i == abort_idx) begin
                abort = 1'b0; in_valid = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_in_ready", 32'(in_ready), 0);
                chk("abort_strobes", 32'({mm_loadp, mm_loada, mm_loadb, mm_en}), 0);
                chk("abort_loads_seen", load_q.size(), 0);
                start = 1'b1; abort = 1'b1;
                @(posedge clk); #1;
                start = 1'b0; abort = 1'b0;
                chk("abort_with_start_idle", 32'(busy), 0);
                $display("op %0d: aborted at word %0d", op_no, abort_idx);
                return;
            end
        end
        in_valid = 1'b0;

        if (rst_mid) begin
            tmo = 0;
            while (outc_cnt < 5 && tmo < 3000) begin @(posedge clk); #1; tmo++; end
            if (outc_cnt < 5) fail_now("unload_start_timeout");
            #2 rst = 1'b1;
            #1 chk_all_zero("async_reset");
            out_q.delete();
            load_q.delete();
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            $display("op %0d: reset mid-unload", op_no);
            return;
        end

        tmo = 0;
        while (busy && tmo < 3000) begin @(posedge clk); #1; tmo++; end
        if (busy) fail_now("operation_timeout");
        chk("mm_en_pulses", en_cnt, 1);
        chk("mm_outc_pulses", outc_cnt, WORDS);
        chk("results_left", out_q.size(), 0);
        chk("loads_left", load_q.size(), 0);
        chk("unload_after_rdy_rise", outc_cyc, rise_cyc + 1);
        if (exp_lat > 0) chk("start_to_mm_en", en_cyc - start_cyc, exp_lat);
        $display("op %0d: skip_p=%0d loads=%0d results=%0d cflag=%b",
                 op_no, skip, nload, outc_cnt, out_cflag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("reset_idle");

        or_mode = 0;
        run_op(0, 0, -1, 50, 20, 16'hC000, 2'b01, 0, 1);       // full load 0x0000..0x002F
        run_op(1, 0, -1, 34, 20, W'($urandom), 2'b11, 0, 0);   // resident modulus
        run_op(1, 0, -1, 0, 300, W'($urandom), 2'b01, 0, 0);   // stale ready, slow finish
        or_mode = 1;
        run_op(1, 0, -1, 0, 15, 16'hC000, 2'b10, 0, 0);        // 1,0,0,1 backpressure
        or_mode = 0;
        run_op(0, 0, WORDS + 7, 0, 20, 16'h0, 2'b00, 0, 0);    // abort at A word 7
        run_op(0, 0, -1, 50, 20, W'($urandom), 2'b01, 0, 0);   // clean after abort
        run_op(0, 0, -1, 0, 10, W'($urandom), 2'b11, 1, 0);    // reset mid-unload
        run_op(0, 0, -1, 50, 10, W'($urandom), 2'b10, 0, 0);   // clean after reset
        or_mode = 2;
        for (int n = 0; n < 3; n++)
            run_op(0, 1, -1, 0, $urandom_range(3, 40), W'($urandom),
                   2'($urandom_range(0, 3)), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
